// File: rtl/de2i_150_qsys_led_seq_pkg.sv
// -----------------------------------------------------------------------------
// de2i_150_qsys_led_seq_pkg
// Shared definitions for the LED sequencer: FSM state encoding, the layout of
// a display word and a helper that splits a raw word into its fields.
//   word[17:0]  -> red LEDs
//   word[26:18] -> green LEDs
//   word[31:27] -> hold time in prescaler ticks (0 = show until next word)
// -----------------------------------------------------------------------------
package de2i_150_qsys_led_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_e;

  localparam int WORD_W   = 32;
  localparam int LEDR_LSB = 0;
  localparam int LEDR_W   = 18;
  localparam int LEDG_LSB = 18;
  localparam int LEDG_W   = 9;
  localparam int HOLD_LSB = 27;
  localparam int HOLD_W   = 5;

  typedef struct packed {
    logic [HOLD_W-1:0] hold;
    logic [LEDG_W-1:0] ledg;
    logic [LEDR_W-1:0] ledr;
  } led_word_t;

  function automatic led_word_t decode_word(input logic [WORD_W-1:0] w);
    led_word_t r;
    r.ledr = w[LEDR_LSB +: LEDR_W];
    r.ledg = w[LEDG_LSB +: LEDG_W];
    r.hold = w[HOLD_LSB +: HOLD_W];
    return r;
  endfunction

endpackage

// File: rtl/de2i_150_qsys_led_seq_fifo.sv
// -----------------------------------------------------------------------------
// de2i_150_qsys_led_seq_fifo
// Synchronous word buffer with the head word always presented on rd_data
// (taken straight from the registered storage), so a pop consumes the word
// that is visible in the same cycle.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset (clears pointers)
//   push, wr_data       : write request / data; accepted when not full, or when
//                         full and a pop happens in the same cycle
//   pop                 : consume the head word (ignored when empty)
//   rd_data             : head word
//   empty, full, level  : occupancy status
// -----------------------------------------------------------------------------
module de2i_150_qsys_led_seq_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] entry_rd [DEPTH];
  logic             push_ok, pop_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full buffer still takes a word when the head leaves in the same cycle:
  // the write lands in the slot being vacated.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Pointers are AW bits wide and DEPTH is a power of two, so the natural
    // overflow of the increment is the modulo-DEPTH wrap.
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage entries carry no reset: stale contents are unreachable once the
  // pointers and level are cleared.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] data_q;
    always_ff @(posedge clk) begin
      if (push_ok && (wr_ptr_q == AW'(gi))) data_q <= wr_data;
    end
    assign entry_rd[gi] = data_q;
  end

  assign rd_data = entry_rd[rd_ptr_q];
  assign level   = level_q;

endmodule

// File: rtl/de2i_150_qsys_led_sequencer.sv
// -----------------------------------------------------------------------------
// de2i_150_qsys_led_sequencer
// Buffers display words arriving from the LED register's read path and plays
// them out on the red/green LEDs, holding each for a programmable number of
// prescaler ticks.
// Ports:
//   clk, reset_n  : system clock, asynchronous active-low reset
//   in_data       : display word {hold[4:0], ledg[8:0], ledr[17:0]}
//   in_valid      : one-cycle strobe qualifying in_data (no backpressure)
//   clear_ovf     : synchronous clear of the sticky overflow flag
//   ledr, ledg    : registered LED patterns
//   fifo_level    : number of buffered words
//   overflow      : sticky, set when a word had to be dropped
//   busy          : sequencer active or words waiting
// -----------------------------------------------------------------------------
module de2i_150_qsys_led_sequencer
  import de2i_150_qsys_led_seq_pkg::*;
#(
  parameter  int FIFO_DEPTH = 8,
  parameter  int TICK_DIV   = 50000,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   in_data,
  input  logic          in_valid,
  input  logic          clear_ovf,
  output logic [17:0]   ledr,
  output logic [8:0]    ledg,
  output logic [LW-1:0] fifo_level,
  output logic          overflow,
  output logic          busy
);

  localparam int              PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

  seq_state_e          state_q, state_d;
  logic [LEDR_W-1:0]   ledr_q, ledr_d;
  logic [LEDG_W-1:0]   ledg_q, ledg_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                ovf_q, ovf_d;

  logic [WORD_W-1:0]   head_raw;
  led_word_t           head;
  logic                fifo_empty, fifo_full;
  logic                pop, push, drop, tick;

  // The head word is consumed exactly in the LOAD cycle.
  assign pop  = (state_q == ST_LOAD);
  assign push = in_valid && (!fifo_full || pop);
  assign drop = in_valid && fifo_full && !pop;
  assign tick = (presc_q == PRESC_LAST);
  assign head = decode_word(head_raw);

  de2i_150_qsys_led_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (head_raw),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    ledr_d     = ledr_q;
    ledg_d     = ledg_q;
    hold_cnt_d = hold_cnt_q;
    presc_d    = presc_q;
    // A drop in the same cycle as a clear leaves the flag set.
    ovf_d      = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (!fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ledr_d     = head.ledr;
        ledg_d     = head.ledg;
        hold_cnt_d = head.hold;
        presc_d    = '0;
        state_d    = (head.hold != '0) ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (tick) begin
          presc_d    = '0;
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          if (hold_cnt_d == '0) state_d = ST_IDLE;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ledr_q     <= '0;
      ledg_q     <= '0;
      hold_cnt_q <= '0;
      presc_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
      hold_cnt_q <= hold_cnt_d;
      presc_q    <= presc_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ledr     = ledr_q;
  assign ledg     = ledg_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_de2i_150_qsys_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_de2i_150_qsys_led_sequencer
// Directed scenarios plus a random phase, every cycle compared against a
// timing-rule model: a word pushed in cycle c can be loaded no earlier than
// c+2; after a LOAD in cycle L with hold H the word is shown for H*TICK_DIV+1
// cycles, so the next LOAD is no earlier than L+H*TICK_DIV+2.
// -----------------------------------------------------------------------------
module tb_de2i_150_qsys_led_sequencer;

  localparam int DEPTH = 4;
  localparam int TD    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [31:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          clear_ovf = 1'b0;
  logic [17:0]   ledr;
  logic [8:0]    ledg;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int max_level = 0;

  // Reference model state
  logic [31:0] mq[$];
  int          mav[$];
  int          cyc;
  int          ready;
  int          hold_end;
  logic [17:0] m_ledr;
  logic [8:0]  m_ledg;
  logic        m_ovf;

  always #5 clk = ~clk;

  de2i_150_qsys_led_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .TICK_DIV   (TD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .clear_ovf  (clear_ovf),
    .ledr       (ledr),
    .ledg       (ledg),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic bit model_busy();
    return (mq.size() != 0) || (cyc <= hold_end);
  endfunction

  function automatic bit model_load_now();
    return (mq.size() > 0) && (mav[0] <= cyc) && (cyc >= ready);
  endfunction

  task automatic model_reset();
    mq.delete();
    mav.delete();
    cyc      = 0;
    ready    = 0;
    hold_end = -1;
    m_ledr   = '0;
    m_ledg   = '0;
    m_ovf    = 1'b0;
  endtask

  // Advance the model over the cycle that ends at the current clock edge.
  task automatic model_cycle();
    bit   was_full;
    bit   ld;
    bit   drop;
    logic [31:0] w;
    int   h;
    was_full = (mq.size() == DEPTH);
    ld   = 1'b0;
    drop = 1'b0;
    if (model_load_now()) begin
      w = mq.pop_front();
      void'(mav.pop_front());
      m_ledr   = w[17:0];
      m_ledg   = w[26:18];
      h        = int'(w[31:27]);
      hold_end = cyc + h * TD;
      ready    = cyc + h * TD + 2;
      ld       = 1'b1;
    end
    if (in_valid) begin
      if (!was_full || ld) begin
        mq.push_back(in_data);
        mav.push_back(cyc + 2);
      end else begin
        drop = 1'b1;
      end
    end
    if (drop)           m_ovf = 1'b1;
    else if (clear_ovf) m_ovf = 1'b0;
    cyc++;
  endtask

  task automatic check_all();
    chk("ledr",     32'(ledr),       32'(m_ledr));
    chk("ledg",     32'(ledg),       32'(m_ledg));
    chk("level",    32'(fifo_level), 32'(mq.size()));
    chk("overflow", 32'(overflow),   32'(m_ovf));
    chk("busy",     32'(busy),       32'(model_busy()));
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
  endtask

  task automatic clock_and_check();
    @(posedge clk);
    model_cycle();
    #1;
    check_all();
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic clr);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    clear_ovf = clr;
    clock_and_check();
  endtask

  task automatic run_until_quiet(input int limit, input string tag);
    int n;
    n = 0;
    do begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end while ((busy !== 1'b0 || model_busy()) && n < limit);
    chk({tag, "_quiet_cycles_lt_limit"}, 32'(n < limit), 32'd1);
  endtask

  // Asynchronous reset pulse applied between clock edges.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h0800_0123;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    clock_and_check();
  endtask

  initial begin
    logic [31:0] d;
    int n;

    // Power-up reset
    model_reset();
    #1;
    reset_n = 1'b0;
    #1;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    clock_and_check();

    // Single hold=2 word: visible two edges after the strobe, then idle
    step(1'b1, 32'h1003_FFFF, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("single_ledr", 32'(ledr), 32'h3FFFF);
    chk("single_ledg", 32'(ledg), 32'h0);
    run_until_quiet(50, "single");

    // Two hold=0 words one cycle apart: level never exceeds 1
    max_level = 0;
    step(1'b1, 32'h0000_0001, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_0002, 1'b0);
    run_until_quiet(30, "pair");
    chk("pair_peak_level", 32'(max_level), 32'd1);
    chk("pair_last_ledr",  32'(ledr),      32'd2);

    // Six strobes while a hold=31 word is shown: four buffered, two dropped,
    // the last drop coincides with clear_ovf
    step(1'b1, 32'hF800_0111, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 32'h0000_0200 + 32'(i), (i == 5));
    chk("burst_level",    32'(fifo_level), 32'd4);
    chk("burst_overflow", 32'(overflow),   32'd1);
    step(1'b0, 32'h0, 1'b1);
    chk("clear_overflow", 32'(overflow),   32'd0);
    run_until_quiet(300, "burst");
    chk("burst_last_ledr", 32'(ledr), 32'h203);

    // Full buffer with a push landing in the LOAD cycle
    step(1'b1, 32'h1800_00AA, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0800_0300 + 32'(i), 1'b0);
    n = 0;
    while (!model_load_now() && n < 100) begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end
    chk("load_wait_lt_limit", 32'(n < 100), 32'd1);
    step(1'b1, 32'h0000_0355, 1'b0);
    chk("load_push_level",    32'(fifo_level), 32'd4);
    chk("load_push_overflow", 32'(overflow),   32'd0);
    run_until_quiet(200, "loadpush");
    chk("load_push_last_ledr", 32'(ledr), 32'h355);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      d = $urandom;
      d[31:27] = 5'($urandom_range(0, 2));
      step(($urandom_range(0, 3) == 0), d, ($urandom_range(0, 7) == 0));
    end
    run_until_quiet(200, "random");

    // Reset in the middle of a long hold, then normal operation again
    step(1'b1, 32'hF9FF_0F0F, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0);
    pulse_reset();
    step(1'b1, 32'h0004_0ABC, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("post_reset_ledr", 32'(ledr), 32'h00ABC);
    chk("post_reset_ledg", 32'(ledg), 32'h001);
    run_until_quiet(30, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
